rob_commit: RTL and testbench



---
 rtl/rob_commit.sv | 146 ++++++++++++++
 tb/tb_rob_commit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rob_commit.sv
// In-order retirement buffer. It snoops the CDB for results of pending entries
// and emits a registered one-cycle commit pulse per retired entry, in program order.
module rob_commit #(
    parameter int                   DEPTH     = 4,
    parameter int                   TAG_W     = 4,
    parameter int                   DATA_W    = 16,
    parameter int                   REG_W     = 4,
    parameter logic [DATA_W-1:0]    SEM_VALOR = 16'hFFF0,
    localparam int                  PTR_W     = $clog2(DEPTH),
    localparam int                  CNT_W     = PTR_W + 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              Alloc_valid,
    input  logic [TAG_W-1:0]  Alloc_rs_tag,
    input  logic [REG_W-1:0]  Alloc_R_target,
    output logic              Alloc_ready,
    input  logic [TAG_W-1:0]  Qi_CDB,
    input  logic [DATA_W-1:0] Qi_CDB_data,
    output logic              Commit_enable,
    output logic [REG_W-1:0]  Commit_R_target,
    output logic [DATA_W-1:0] Commit_data,
    output logic [TAG_W-1:0]  Commit_rs_tag,
    output logic [CNT_W-1:0]  Count,
    output logic              Full,
    output logic              Empty
);

    logic [DEPTH-1:0]  valid_r;
    logic [DEPTH-1:0]  ready_r;
    logic [TAG_W-1:0]  tag_r  [DEPTH];
    logic [REG_W-1:0]  targ_r [DEPTH];
    logic [DATA_W-1:0] data_r [DEPTH];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;

    logic              commit_en_r;
    logic [REG_W-1:0]  commit_targ_r;
    logic [DATA_W-1:0] commit_data_r;
    logic [TAG_W-1:0]  commit_tag_r;

    logic              full_s;
    logic              alloc_s;
    logic              retire_s;
    logic              match_found_s;
    logic [PTR_W-1:0]  match_idx_s;
    logic              hit_s;

    assign full_s   = (count_r == CNT_W'(DEPTH));
    assign alloc_s  = Alloc_valid && !full_s;
    assign retire_s = valid_r[head_r] && ready_r[head_r];

    // Oldest pending entry waiting on the broadcasting station, searched from head.
    // A slot being allocated this cycle is still invalid here, so it cannot match.
    always_comb begin
        match_found_s = 1'b0;
        match_idx_s   = head_r;
        hit_s         = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_s = (Qi_CDB != {TAG_W{1'b0}})
                    && valid_r[head_r + PTR_W'(i)]
                    && !ready_r[head_r + PTR_W'(i)]
                    && (tag_r[head_r + PTR_W'(i)] == Qi_CDB);
            match_idx_s   = (!match_found_s && hit_s) ? (head_r + PTR_W'(i)) : match_idx_s;
            match_found_s = match_found_s | hit_s;
        end
    end

    // Entry array, pointers, occupancy and commit outputs; Reset > Flush > normal.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_r[i]  <= {TAG_W{1'b0}};
                targ_r[i] <= {REG_W{1'b0}};
                data_r[i] <= SEM_VALOR;
            end
            valid_r       <= {DEPTH{1'b0}};
            ready_r       <= {DEPTH{1'b0}};
            head_r        <= {PTR_W{1'b0}};
            tail_r        <= {PTR_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
            commit_en_r   <= 1'b0;
            commit_targ_r <= {REG_W{1'b0}};
            commit_data_r <= SEM_VALOR;
            commit_tag_r  <= {TAG_W{1'b0}};
        end else if (Flush) begin
            // Commit payload deliberately holds its last value across a flush.
            for (int i = 0; i < DEPTH; i++) begin
                tag_r[i]  <= {TAG_W{1'b0}};
                targ_r[i] <= {REG_W{1'b0}};
                data_r[i] <= SEM_VALOR;
            end
            valid_r     <= {DEPTH{1'b0}};
            ready_r     <= {DEPTH{1'b0}};
            head_r      <= {PTR_W{1'b0}};
            tail_r      <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            commit_en_r <= 1'b0;
        end else begin
            commit_en_r <= retire_s;
            if (retire_s) begin
                commit_targ_r   <= targ_r[head_r];
                commit_data_r   <= data_r[head_r];
                commit_tag_r    <= tag_r[head_r];
                valid_r[head_r] <= 1'b0;
                ready_r[head_r] <= 1'b0;
                head_r          <= head_r + PTR_W'(1);
            end else begin
                head_r <= head_r;
            end
            if (match_found_s) begin
                data_r[match_idx_s]  <= Qi_CDB_data;
                ready_r[match_idx_s] <= 1'b1;
            end else begin
                ready_r[match_idx_s] <= ready_r[match_idx_s];
            end
            if (alloc_s) begin
                valid_r[tail_r] <= 1'b1;
                ready_r[tail_r] <= 1'b0;
                tag_r[tail_r]   <= Alloc_rs_tag;
                targ_r[tail_r]  <= Alloc_R_target;
                data_r[tail_r]  <= SEM_VALOR;
                tail_r          <= tail_r + PTR_W'(1);
            end else begin
                tail_r <= tail_r;
            end
            case ({alloc_s, retire_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign Alloc_ready     = !full_s;
    assign Full            = full_s;
    assign Empty           = (count_r == {CNT_W{1'b0}});
    assign Count           = count_r;
    assign Commit_enable   = commit_en_r;
    assign Commit_R_target = commit_targ_r;
    assign Commit_data     = commit_data_r;
    assign Commit_rs_tag   = commit_tag_r;

endmodule

// File: tb/tb_rob_commit.sv
// Randomized + directed bench for rob_commit: a queue-based reference model
// predicts commits into a scoreboard that a negedge monitor drains and checks.
module tb_rob_commit;

    localparam int DEPTH = 4;
    localparam logic [15:0] SEM = 16'hFFF0;

    logic        Clock = 1'b0;
    logic        Reset, Flush, Alloc_valid;
    logic [3:0]  Alloc_rs_tag, Alloc_R_target, Qi_CDB;
    logic [15:0] Qi_CDB_data;
    logic        Alloc_ready, Commit_enable, Full, Empty;
    logic [3:0]  Commit_R_target, Commit_rs_tag;
    logic [15:0] Commit_data;
    logic [2:0]  Count;

    rob_commit #(.DEPTH(DEPTH), .TAG_W(4), .DATA_W(16), .REG_W(4), .SEM_VALOR(16'hFFF0)) dut (
        .Clock(Clock), .Reset(Reset), .Flush(Flush),
        .Alloc_valid(Alloc_valid), .Alloc_rs_tag(Alloc_rs_tag), .Alloc_R_target(Alloc_R_target),
        .Alloc_ready(Alloc_ready), .Qi_CDB(Qi_CDB), .Qi_CDB_data(Qi_CDB_data),
        .Commit_enable(Commit_enable), .Commit_R_target(Commit_R_target),
        .Commit_data(Commit_data), .Commit_rs_tag(Commit_rs_tag),
        .Count(Count), .Full(Full), .Empty(Empty)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [3:0]  tag;
        logic [3:0]  rt;
        logic [15:0] data;
        logic        rdy;
    } ent_t;

    ent_t mq[$];   // model buffer contents, oldest first
    ent_t eq[$];   // expected commits, oldest first
    ent_t last_c;  // last committed payload (held on non-commit cycles)

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  mon_on   = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model of one clock edge, using inputs as sampled at that edge.
    task automatic model_edge();
        bit retire;
        if (!Reset) begin
            mq.delete();
            eq.delete();
            last_c = '{tag: 4'd0, rt: 4'd0, data: SEM, rdy: 1'b0};
        end else if (Flush) begin
            mq.delete();
        end else begin
            int sz_before = mq.size();
            retire = (mq.size() > 0) && mq[0].rdy;
            if (Qi_CDB != 4'd0) begin
                for (int i = 0; i < mq.size(); i++) begin
                    if (!mq[i].rdy && mq[i].tag == Qi_CDB) begin
                        mq[i].data = Qi_CDB_data;
                        mq[i].rdy  = 1'b1;
                        break;
                    end
                end
            end
            if (retire) eq.push_back(mq.pop_front());
            if (Alloc_valid && sz_before < DEPTH)
                mq.push_back('{tag: Alloc_rs_tag, rt: Alloc_R_target, data: SEM, rdy: 1'b0});
        end
    endtask

    task automatic step(input logic rst, input logic fl, input logic av,
                        input logic [3:0] tg, input logic [3:0] rt,
                        input logic [3:0] cdb, input logic [15:0] d);
        Reset = rst; Flush = fl; Alloc_valid = av; Alloc_rs_tag = tg;
        Alloc_R_target = rt; Qi_CDB = cdb; Qi_CDB_data = d;
        @(posedge Clock);
        model_edge();
        @(negedge Clock);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 16'h0000);
    endtask

    // Monitor: occupancy flags every cycle; commit payload against the scoreboard.
    always @(negedge Clock) begin
        if (mon_on) begin
            chk("count", int'(Count), mq.size());
            chk("full", int'(Full), int'(mq.size() == DEPTH));
            chk("empty", int'(Empty), int'(mq.size() == 0));
            chk("alloc_ready", int'(Alloc_ready), int'(mq.size() != DEPTH));
            if (Commit_enable) begin
                if (eq.size() == 0) begin
                    chk("spurious_commit", 1, 0);
                end else begin
                    last_c = eq.pop_front();
                    chk("commit_rt", int'(Commit_R_target), int'(last_c.rt));
                    chk("commit_data", int'(Commit_data), int'(last_c.data));
                    chk("commit_tag", int'(Commit_rs_tag), int'(last_c.tag));
                end
            end else begin
                if (eq.size() != 0) begin
                    chk("missing_commit", 0, eq.size());
                    eq.delete();
                end
                chk("held_rt", int'(Commit_R_target), int'(last_c.rt));
                chk("held_data", int'(Commit_data), int'(last_c.data));
                chk("held_tag", int'(Commit_rs_tag), int'(last_c.tag));
            end
        end
    end

    initial begin
        Reset = 1'b0; Flush = 1'b0; Alloc_valid = 1'b0; Alloc_rs_tag = 4'd0;
        Alloc_R_target = 4'd0; Qi_CDB = 4'd0; Qi_CDB_data = 16'h0000;
        @(negedge Clock);
        step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 16'h0000);
        mon_on = 1'b1;
        step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 16'h0000);
        chk("reset_commit_data", int'(Commit_data), int'(SEM));
        chk("reset_commit_en", int'(Commit_enable), 0);
        idle(1);

        // Single alloc then capture: pulse appears two edges after the CDB edge's predecessor.
        step(1'b1, 1'b0, 1'b1, 4'd1, 4'd3, 4'd0, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1, 16'h0005);
        chk("no_bypass", int'(Commit_enable), 0);
        idle(1);
        chk("single_commit_en", int'(Commit_enable), 1);
        chk("single_commit_data", int'(Commit_data), 16'h0005);
        idle(2);

        // Out-of-order completion still commits in order.
        step(1'b1, 1'b0, 1'b1, 4'd1, 4'd1, 4'd0, 16'h0000);
        step(1'b1, 1'b0, 1'b1, 4'd2, 4'd2, 4'd0, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd2, 16'h0022);
        idle(1);
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1, 16'h0011);
        idle(4);

        // Fill, dropped fifth alloc, drain, refill across the wrap.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 4'(i + 1), 4'(i), 4'd0, 16'h0000);
        chk("full_count", int'(Count), 4);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'(i + 1), 16'h0100 + 16'(i));
        idle(5);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 4'(i + 5), 4'(i + 8), 4'd0, 16'h0000);
        for (int i = 3; i >= 0; i--) step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'(i + 5), 16'h0200 + 16'(i));
        idle(6);

        // Same-cycle alloc and broadcast of the same tag: must not capture.
        step(1'b1, 1'b0, 1'b1, 4'd1, 4'd6, 4'd1, 16'h00AA);
        idle(3);
        chk("same_cycle_pending", int'(Count), 1);
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1, 16'h0007);
        idle(3);

        // Flush with entries in flight, one of them ready at head.
        step(1'b1, 1'b0, 1'b1, 4'd1, 4'd1, 4'd0, 16'h0000);
        step(1'b1, 1'b0, 1'b1, 4'd2, 4'd2, 4'd0, 16'h0000);
        step(1'b1, 1'b0, 1'b1, 4'd3, 4'd3, 4'd1, 16'h0033);
        step(1'b1, 1'b1, 1'b1, 4'd4, 4'd4, 4'd2, 16'h0044);
        chk("flush_empty", int'(Empty), 1);
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd3, 16'h0055);
        idle(3);

        // Randomized traffic with small tag space to exercise duplicate tags.
        for (int c = 0; c < 600; c++) begin
            logic av, fl;
            logic [3:0] cdb;
            av  = ($urandom_range(0, 99) < 55);
            fl  = ($urandom_range(0, 99) < 2);
            cdb = ($urandom_range(0, 99) < 60) ? 4'($urandom_range(1, 4)) : 4'd0;
            step(1'b1, fl, av, 4'($urandom_range(1, 4)), 4'($urandom_range(0, 15)),
                 cdb, 16'($urandom_range(0, 65535)));
        end

        // Drain: sweep tags until the model is empty, bounded.
        for (int c = 0; c < 200 && mq.size() != 0; c++)
            step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'((c % 4) + 1), 16'($urandom_range(0, 65535)));
        idle(4);
        chk("drained", mq.size(), 0);

        mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
